// File: rtl/uart_rx_frame.sv
// UART receive engine: self-timed start detection, DATA_WIDTH data bits, optional parity, STOP_BITS stop bits.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit; default is a single mid-bit sample.
module uart_rx_frame #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE   = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_error,
  output logic                  stop_error,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(PRESCALE);
  localparam int unsigned BW = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] S_CNT     = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] LAST_CNT  = CW'(PRESCALE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                  state;
  logic [CW-1:0]           edge_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   shift;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    par_flag;
  logic                    stop_flag;
  logic                    armed;

  logic                    bit_val;
  logic                    at_dec;
  logic                    last_edge;
  logic [CW-1:0]           edge_nxt;
  logic                    frame_stop_err;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] DEC_CNT = CW'(PRESCALE / 2 + 1);

  logic [1:0] smp;

  // smp[0]/smp[1] hold the S-1 and S samples; the live line is the third vote at S+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp <= '0;
    end else begin
      if (edge_cnt == S_CNT - CW'(1)) smp[0] <= rx_in;
      if (edge_cnt == S_CNT)          smp[1] <= rx_in;
    end
  end

  assign bit_val = (smp[0] & smp[1]) | (smp[0] & rx_in) | (smp[1] & rx_in);
`else
  localparam logic [CW-1:0] DEC_CNT = S_CNT;

  assign bit_val = rx_in;
`endif

  assign at_dec         = (edge_cnt == DEC_CNT);
  assign last_edge      = (edge_cnt == LAST_CNT);
  assign edge_nxt       = last_edge ? '0 : edge_cnt + CW'(1);
  assign frame_stop_err = stop_flag | ~bit_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_flag   <= 1'b0;
      stop_flag  <= 1'b0;
      armed      <= 1'b1;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_error  <= 1'b0;
      stop_error <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          edge_cnt <= '0;
          if (armed && !rx_in) begin
            state     <= START;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
            par_flag  <= 1'b0;
            stop_flag <= 1'b0;
          end
        end

        START: begin
          edge_cnt <= edge_nxt;
          if (at_dec && bit_val) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (last_edge) begin
            state <= DATA;
          end
        end

        DATA: begin
          edge_cnt <= edge_nxt;
          if (at_dec) shift <= {bit_val, shift[DATA_WIDTH-1:1]};
          if (last_edge) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end

        PARITY: begin
          edge_cnt <= edge_nxt;
          if (at_dec) par_flag <= bit_val ^ (^shift) ^ par_typ_q;
          if (last_edge) state <= STOP;
        end

        STOP: begin
          edge_cnt <= edge_nxt;
          if (at_dec) begin
            if (bit_cnt == LAST_STOP) begin
              // Frame closes mid-stop-bit so the next start edge is caught early.
              p_data     <= shift;
              par_error  <= par_flag;
              stop_error <= frame_stop_err;
              data_valid <= 1'b1;
              busy       <= 1'b0;
              armed      <= ~frame_stop_err;
              state      <= frame_stop_err ? WAIT_HIGH : IDLE;
            end else begin
              stop_flag <= frame_stop_err;
            end
          end
          if (last_edge) bit_cnt <= bit_cnt + BW'(1);
        end

        WAIT_HIGH: begin
          edge_cnt <= '0;
          if (rx_in) begin
            armed <= 1'b1;
            state <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          edge_cnt <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: pre-built line waveform, frame-level reference model, per-cycle compare.
module tb_uart_rx_frame;

  localparam int DW   = 8;
  localparam int P    = 16;
  localparam int SB   = 1;
  localparam int S    = P / 2;
  localparam int MAXL = 16384;
`ifdef UART_RX_MAJORITY_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_in = 1'b1;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_error;
  logic          stop_error;
  logic          busy;

  uart_rx_frame #(
    .DATA_WIDTH(DW),
    .PRESCALE  (P),
    .STOP_BITS (SB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .par_en    (par_en),
    .par_typ   (par_typ),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_error (par_error),
    .stop_error(stop_error),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // ln[e] is the line value present at clock edge e; outputs after edge e are checked against ex_w[e].
  bit            ln   [MAXL];
  bit            pe_a [MAXL];
  bit            pt_a [MAXL];
  bit            rl_a [MAXL];
  logic [DW+3:0] ex_w [MAXL];
  logic [DW+3:0] act_w[MAXL];
  int            len = 0;
  bit            cur_pe = 0;
  bit            cur_pt = 0;

  int vectors = 0;
  int miscompares = 0;

  int s_a5, s_3c, s_fs, s_55, s_brk, s_rs, s_c3, s_gl;

  task automatic put(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      ln[len] = v; pe_a[len] = cur_pe; pt_a[len] = cur_pt; rl_a[len] = 1'b0;
      len++;
    end
  endtask

  task automatic send(input logic [DW-1:0] data, input bit has_par, input bit par_bit,
                      input bit stop_bit, output int start);
    start = len;
    put(1'b0, P);
    for (int i = 0; i < DW; i++) put(data[i], P);
    if (has_par) put(par_bit, P);
    for (int i = 0; i < SB; i++) put(stop_bit, P);
  endtask

  function automatic bit at(input int i);
    return (i < len) ? ln[i] : 1'b1;
  endfunction

  // Value of bit b of the frame starting at edge t0, as the spec defines its sample point(s).
  function automatic bit samp(input int t0, input int b);
    int base;
    bit a, m, c;
    base = t0 + b * P + S;
    a = at(base); m = at(base + 1); c = at(base + 2);
    if (D == 1) return (a & m) | (a & c) | (m & c);
    return m;
  endfunction

  function automatic void build_model();
    int            mode = 0;
    int            t0 = 0;
    int            dec = 0;
    int            n;
    bit            fs = 0;
    bit            lp, lt;
    logic [DW-1:0] pd = '0;
    logic [DW-1:0] npd = '0;
    bit            pe = 0, se = 0, bz = 0, dv = 0, nperr = 0, nserr = 0;
    for (int e = 0; e < len; e++) begin
      dv = 1'b0;
      if (rl_a[e]) begin
        mode = 0; pd = '0; pe = 0; se = 0; bz = 0;
      end else begin
        case (mode)
          0: if (!ln[e]) begin
            t0 = e; lp = pe_a[e]; lt = pt_a[e]; bz = 1'b1; mode = 1;
            fs = samp(t0, 0);
            if (fs) begin
              dec = t0 + S + 1 + D;
            end else begin
              for (int i = 0; i < DW; i++) npd[i] = samp(t0, 1 + i);
              n = 1 + DW + int'(lp) + SB;
              nperr = lp && (samp(t0, 1 + DW) != ((^npd) ^ lt));
              nserr = 1'b0;
              for (int k = 0; k < SB; k++) if (!samp(t0, 1 + DW + int'(lp) + k)) nserr = 1'b1;
              dec = t0 + (n - 1) * P + S + 1 + D;
            end
          end
          1: if (e == dec) begin
            bz = 1'b0;
            if (fs) mode = 0;
            else begin
              pd = npd; pe = nperr; se = nserr; dv = 1'b1;
              mode = nserr ? 2 : 0;
            end
          end
          2: if (ln[e]) mode = 0;
          default: mode = 0;
        endcase
      end
      ex_w[e] = {bz, dv, pe, se, pd};
    end
  endfunction

  task automatic build_stimulus();
    int  st, kind, gap, g;
    bit  pbit, sbit;
    logic [DW-1:0] d;
    put(1'b1, 20);
    for (int i = 0; i < 3; i++) rl_a[i] = 1'b1;

    cur_pe = 1; cur_pt = 0;
    send(8'hA5, 1, 1'b0, 1'b1, s_a5); put(1'b1, 10);
    cur_pt = 1;
    send(8'h3C, 1, 1'b0, 1'b1, s_3c); put(1'b1, 10);
    cur_pe = 0; cur_pt = 0;
    s_fs = len; put(1'b0, 4); put(1'b1, 20);
    send(8'h55, 0, 1'b0, 1'b1, s_55); put(1'b1, 10);
    send(8'h00, 0, 1'b0, 1'b0, s_brk); put(1'b0, 40); put(1'b1, 30);
    send(8'hF8, 0, 1'b0, 1'b1, s_rs);
    for (int i = 70; i < 73; i++) rl_a[s_rs + i] = 1'b1;
    put(1'b1, 30);
    send(8'hC3, 0, 1'b0, 1'b1, s_c3); put(1'b1, 10);
    send(8'h0F, 0, 1'b0, 1'b1, s_gl);
    ln[s_gl + 4 * P + S + 1] = ~ln[s_gl + 4 * P + S + 1];
    put(1'b1, 20);

    while (len < MAXL - 700) begin
      cur_pe = 1'($urandom_range(0, 1));
      cur_pt = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        put(1'b0, int'($urandom_range(1, S)));
      end else begin
        d    = DW'($urandom);
        pbit = (^d) ^ cur_pt ^ ($urandom_range(0, 3) == 0);
        sbit = ($urandom_range(0, 7) != 0);
        send(d, cur_pe, pbit, sbit, st);
        // Parity inputs wander after the start edge; only the start-edge value may count.
        for (int i = st + 1; i < len; i++) begin
          pe_a[i] = 1'($urandom_range(0, 1));
          pt_a[i] = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 2) == 0) begin
          g = st + int'($urandom_range(0, len - st - 1));
          ln[g] = ~ln[g];
        end
      end
      gap = int'($urandom_range(0, 25));
      put(1'b1, gap);
    end
    put(1'b1, 300);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int first_dv(input int from, input int to);
    for (int e = from; e < to && e < len; e++) if (act_w[e][DW+2]) return e;
    return -1;
  endfunction

  function automatic int count_dv(input int from, input int to);
    int c = 0;
    for (int e = from; e < to && e < len; e++) if (act_w[e][DW+2]) c++;
    return c;
  endfunction

  task automatic chk_frame(input string name, input int start, input int delay,
                           input int pd, input int pe, input int se);
    int e;
    e = first_dv(start, start + 300);
    chk({name, "_latency"}, (e < 0) ? -1 : e - start, delay);
    chk({name, "_p_data"},  (e < 0) ? -1 : int'(act_w[e][DW-1:0]), pd);
    chk({name, "_par_err"}, (e < 0) ? -1 : int'(act_w[e][DW+1]), pe);
    chk({name, "_stop_err"},(e < 0) ? -1 : int'(act_w[e][DW]), se);
  endtask

  initial begin : drive
    build_stimulus();
    build_model();
    rst = ~rl_a[0]; rx_in = ln[0]; par_en = pe_a[0]; par_typ = pt_a[0];
    for (int e = 0; e < len - 1; e++) begin
      @(posedge clk);
      #1;
      rst = ~rl_a[e]; rx_in = ln[e + 1]; par_en = pe_a[e + 1]; par_typ = pt_a[e + 1];
    end
  end

  initial begin : compare
    logic [DW+3:0] w;
    int            n_model_dv = 0;
    #1;
    for (int e = 0; e < len; e++) begin
      @(negedge clk);
      w = {busy, data_valid, par_error, stop_error, p_data};
      act_w[e] = w;
      if (ex_w[e][DW+2]) n_model_dv++;
      vectors++;
      if (w !== ex_w[e]) begin
        miscompares++;
        $display("FAIL cycle_%0d: got busy=%b dv=%b pe=%b se=%b pd=%h, expected busy=%b dv=%b pe=%b se=%b pd=%h",
                 e, w[DW+3], w[DW+2], w[DW+1], w[DW], w[DW-1:0],
                 ex_w[e][DW+3], ex_w[e][DW+2], ex_w[e][DW+1], ex_w[e][DW], ex_w[e][DW-1:0]);
      end
    end

    chk_frame("8E1_A5", s_a5, 169 + D, 8'hA5, 0, 0);
    chk_frame("8O1_3C", s_3c, 169 + D, 8'h3C, 1, 0);
    chk("false_start_busy_hi", int'(act_w[s_fs + 8 + D][DW+3]), 1);
    chk("false_start_busy_lo", int'(act_w[s_fs + 9 + D][DW+3]), 0);
    chk("false_start_no_dv", count_dv(s_fs, s_55), 0);
    chk_frame("8N1_55", s_55, 153 + D, 8'h55, 0, 0);
    chk_frame("break", s_brk, 153 + D, 8'h00, 0, 1);
    chk("break_single_dv", count_dv(s_brk, s_rs), 1);
    chk("reset_busy_before", int'(act_w[s_rs + 69][DW+3]), 1);
    chk("reset_outputs_zero", int'(act_w[s_rs + 70]), 0);
    chk("reset_no_dv", count_dv(s_rs, s_c3), 0);
    chk_frame("after_reset_C3", s_c3, 153 + D, 8'hC3, 0, 0);
    chk_frame("glitch_0F", s_gl, 153 + D, (D == 1) ? 8'h0F : 8'h07, 0, 0);
    chk("total_strobes", count_dv(0, len), n_model_dv);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
